// File: rtl/pkt_buf_pkg.sv
// rtl/pkt_buf_pkg.sv - shared defaults and types for the packet buffer read scheduler
// Purpose: default widths/depths, descriptor type and read FSM state type.
package pkt_buf_pkg;
  localparam int ADDR_WIDTH_DEF = 14;
  localparam int PCK_LEN_DEF    = 12;
  localparam int DESC_DEPTH_DEF = 16;

  typedef struct packed {
    logic [PCK_LEN_DEF-1:0] len;
  } pkt_desc_t;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } rd_state_e;
endpackage

// File: rtl/pkt_rd_sched_if.sv
// rtl/pkt_rd_sched_if.sv - ingress, RAM-flag and egress framing signals of pkt_rd_sched
// Purpose: bundles the scheduler's handshake/bus signals.
// Ports (slave = scheduler side):
//   in : wr_valid, wr_sop, wr_eop, ram_full, ram_empty, out_ready
//   out: wr_ready, ram_rd_en, out_valid, out_sop, out_eop, out_len,
//        desc_count, err_framing, err_oversize
interface pkt_rd_sched_if
  import pkt_buf_pkg::*;
#(
  parameter int PCK_LEN    = PCK_LEN_DEF,
  parameter int DESC_DEPTH = DESC_DEPTH_DEF
);
  localparam int CW = $clog2(DESC_DEPTH) + 1;

  logic               wr_valid;
  logic               wr_sop;
  logic               wr_eop;
  logic               wr_ready;
  logic               ram_full;
  logic               ram_empty;
  logic               ram_rd_en;
  logic               out_ready;
  logic               out_valid;
  logic               out_sop;
  logic               out_eop;
  logic [PCK_LEN-1:0] out_len;
  logic [CW-1:0]      desc_count;
  logic               err_framing;
  logic               err_oversize;

  modport master (
    output wr_valid, wr_sop, wr_eop, ram_full, ram_empty, out_ready,
    input  wr_ready, ram_rd_en, out_valid, out_sop, out_eop, out_len,
           desc_count, err_framing, err_oversize
  );

  modport slave (
    input  wr_valid, wr_sop, wr_eop, ram_full, ram_empty, out_ready,
    output wr_ready, ram_rd_en, out_valid, out_sop, out_eop, out_len,
           desc_count, err_framing, err_oversize
  );
endinterface

// File: rtl/pkt_rd_sched_desc_fifo.sv
// rtl/pkt_rd_sched_desc_fifo.sv - synchronous FIFO of packet length descriptors
// Purpose: holds one descriptor per completed packet until the read FSM pops it.
// Ports: i_clk, i_rst_n (async active-low), i_push/i_desc, i_pop/o_desc (head,
//        valid while !o_empty), o_full, o_empty, o_count.
module pkt_desc_fifo
  import pkt_buf_pkg::*;
#(
  parameter int DEPTH = DESC_DEPTH_DEF
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_push,
  input  pkt_desc_t                  i_desc,
  input  logic                       i_pop,
  output pkt_desc_t                  o_desc,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);
  localparam int AW = $clog2(DEPTH);

  pkt_desc_t     r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_desc  = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_desc;
  end
endmodule

// File: rtl/pkt_rd_sched.sv
// rtl/pkt_rd_sched.sv - packet-aware read scheduler for the shared packet buffer RAM
// Purpose: records one length descriptor per ingress packet and replays the RAM
//          contents as whole-packet bursts with SOP/EOP/len aligned to RAM data.
// Ports: i_clk, i_rst_n (async active-low), bus (pkt_rd_sched_if.slave).
// Optional: PKT_RD_SCHED_STATS_EN adds o_pkt_in_cnt / o_pkt_out_cnt.
module pkt_rd_sched
  import pkt_buf_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int PCK_LEN    = PCK_LEN_DEF,
  parameter int DESC_DEPTH = DESC_DEPTH_DEF
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  pkt_rd_sched_if.slave bus
`ifdef PKT_RD_SCHED_STATS_EN
  ,
  output logic [31:0]   o_pkt_in_cnt,
  output logic [31:0]   o_pkt_out_cnt
`endif
);
  // A packet can never exceed the RAM, and descriptors are stored at PCK_LEN_DEF bits.
  if (PCK_LEN > ADDR_WIDTH || PCK_LEN > PCK_LEN_DEF) begin : g_cfg_chk
    $error("pkt_rd_sched: PCK_LEN out of range");
  end

  localparam logic [PCK_LEN-1:0] MAX_LEN = '1;

  rd_state_e          r_state, w_state_nxt;
  logic               r_in_pkt, r_ovf_cont;
  logic [PCK_LEN-1:0] r_wr_len, w_len_cur;
  logic [PCK_LEN-1:0] r_rem, r_len;
  logic               r_first;
  logic               w_acc, w_force, w_push, w_frm_wr;
  logic               w_pop, w_issue, w_rd_err, w_last;
  logic               w_desc_full, w_desc_empty;
  pkt_desc_t          w_push_desc, w_pop_desc;

  // ---------------- write side ----------------
  assign bus.wr_ready = !bus.ram_full && !w_desc_full;
  assign w_acc        = bus.wr_valid && bus.wr_ready;
  // Any word arriving outside a packet opens one (explicit or implied SOP).
  assign w_len_cur    = r_in_pkt ? r_wr_len + 1'b1 : PCK_LEN'(1);
  assign w_force      = w_acc && !bus.wr_eop && (w_len_cur == MAX_LEN);
  assign w_push       = w_acc && (bus.wr_eop || w_force);
  // The word after a forced EOP legitimately lacks SOP, so it is not a framing error.
  assign w_frm_wr     = w_acc && (r_in_pkt ? bus.wr_sop : (!bus.wr_sop && !r_ovf_cont));
  assign w_push_desc.len = PCK_LEN_DEF'(w_len_cur);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_in_pkt   <= 1'b0;
      r_wr_len   <= '0;
      r_ovf_cont <= 1'b0;
    end else if (w_acc) begin
      r_in_pkt   <= !w_push;
      r_wr_len   <= w_push ? '0 : w_len_cur;
      r_ovf_cont <= w_force;
    end
  end

  pkt_desc_fifo #(.DEPTH(DESC_DEPTH)) u_desc_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_desc  (w_push_desc),
    .i_pop   (w_pop),
    .o_desc  (w_pop_desc),
    .o_full  (w_desc_full),
    .o_empty (w_desc_empty),
    .o_count (bus.desc_count)
  );

  // ---------------- read FSM ----------------
  assign w_last        = (r_rem == PCK_LEN'(1));
  assign bus.ram_rd_en = w_issue;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_issue     = 1'b0;
    w_rd_err    = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_desc_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = BURST;
        end
      end
      BURST: begin
        if (bus.out_ready) begin
          // A credited issue with an empty RAM means descriptors and RAM disagree.
          if (bus.ram_empty) begin
            w_rd_err = 1'b1;
          end else begin
            w_issue = 1'b1;
            if (w_last) begin
              if (!w_desc_empty) w_pop = 1'b1;
              else               w_state_nxt = IDLE;
            end
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rem   <= '0;
      r_len   <= '0;
      r_first <= 1'b0;
    end else if (w_pop) begin
      r_rem   <= PCK_LEN'(w_pop_desc.len);
      r_len   <= PCK_LEN'(w_pop_desc.len);
      r_first <= 1'b1;
    end else if (w_issue) begin
      r_rem   <= r_rem - 1'b1;
      r_first <= 1'b0;
    end
  end

  // Framing outputs trail the rd_en cycle by one, lining up with RAM data_out.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bus.out_valid    <= 1'b0;
      bus.out_sop      <= 1'b0;
      bus.out_eop      <= 1'b0;
      bus.out_len      <= '0;
      bus.err_framing  <= 1'b0;
      bus.err_oversize <= 1'b0;
    end else begin
      bus.out_valid    <= w_issue;
      bus.out_sop      <= w_issue && r_first;
      bus.out_eop      <= w_issue && w_last;
      bus.out_len      <= (w_issue && r_first) ? r_len : '0;
      bus.err_framing  <= bus.err_framing || w_frm_wr || w_rd_err;
      bus.err_oversize <= bus.err_oversize || w_force;
    end
  end

`ifdef PKT_RD_SCHED_STATS_EN
  logic [31:0] r_pkt_in_cnt, r_pkt_out_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pkt_in_cnt  <= '0;
      r_pkt_out_cnt <= '0;
    end else begin
      if (w_push)            r_pkt_in_cnt  <= r_pkt_in_cnt + 32'd1;
      if (w_issue && w_last) r_pkt_out_cnt <= r_pkt_out_cnt + 32'd1;
    end
  end

  assign o_pkt_in_cnt  = r_pkt_in_cnt;
  assign o_pkt_out_cnt = r_pkt_out_cnt;
`endif
endmodule

// File: tb/tb_pkt_rd_sched.sv
// tb/tb_pkt_rd_sched.sv - self-checking bench for pkt_rd_sched
module tb_pkt_rd_sched;
  import pkt_buf_pkg::*;

  localparam int PL   = PCK_LEN_DEF;
  localparam int DD   = DESC_DEPTH_DEF;
  localparam int MAXL = (1 << PL) - 1;

  typedef struct {
    bit sop;
    bit eop;
    int len;
  } word_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pkt_rd_sched_if #(.PCK_LEN(PL), .DESC_DEPTH(DD)) bus ();

`ifdef PKT_RD_SCHED_STATS_EN
  logic [31:0] pkt_in_cnt, pkt_out_cnt;
`endif

  pkt_rd_sched #(.ADDR_WIDTH(ADDR_WIDTH_DEF), .PCK_LEN(PL), .DESC_DEPTH(DD)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
`ifdef PKT_RD_SCHED_STATS_EN
    ,
    .o_pkt_in_cnt  (pkt_in_cnt),
    .o_pkt_out_cnt (pkt_out_cnt)
`endif
  );

  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  int    ram_cnt = 0;
  int    ram_cap = 8192;
  bit    prev_rd = 0;
  bit    last_acc = 0;
  bit    obs_wr_ready = 0;
  bit    rand_rdy = 0;
  word_t exp_q[$];
  bit    m_in_pkt = 0, m_ovf = 0, m_frm = 0, m_ovs = 0;
  int    m_len = 0, m_pushes = 0, m_eops = 0;
  bit    rec = 0;
  int    rd_cyc_q[$];
  int    sop_lens[$];
  int    vcnt = 0;
  bit [15:0] sop_mask, eop_mask;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void m_push(int len);
    for (int i = 0; i < len; i++)
      exp_q.push_back('{sop: (i == 0), eop: (i == len - 1), len: (i == 0) ? len : 0});
    m_pushes++;
  endfunction

  // Reference packetiser: applies the framing, implied-SOP and oversize rules per word.
  function automatic void m_write(bit sop, bit eop);
    if (!m_in_pkt) begin
      if (!sop && !m_ovf) m_frm = 1;
      m_len = 1;
    end else begin
      if (sop) m_frm = 1;
      m_len++;
    end
    m_ovf = 0;
    if (eop) begin
      m_push(m_len);
      m_in_pkt = 0;
    end else if (m_len == MAXL) begin
      m_push(m_len);
      m_ovs = 1;
      m_ovf = 1;
      m_in_pkt = 0;
    end else begin
      m_in_pkt = 1;
    end
  endfunction

  task automatic tick();
    bit    acc, rd;
    word_t w;
    @(negedge clk);
    acc = bus.wr_valid && bus.wr_ready;
    rd  = bus.ram_rd_en;
    obs_wr_ready = bus.wr_ready;
    chk("rd_legal", 64'(rd && !(bus.out_ready && !bus.ram_empty)), 0);
    chk("wr_ready_full", 64'(bus.ram_full && bus.wr_ready), 0);
    chk("valid_align", 64'(bus.out_valid), 64'(prev_rd));
    chk("err_framing", 64'(bus.err_framing), 64'(m_frm));
    chk("err_oversize", 64'(bus.err_oversize), 64'(m_ovs));
    if (bus.out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", 1, 0);
      end else begin
        w = exp_q.pop_front();
        chk("out_sop", 64'(bus.out_sop), 64'(w.sop));
        chk("out_eop", 64'(bus.out_eop), 64'(w.eop));
        chk("out_len", 64'(bus.out_len), 64'(w.len));
        if (w.eop) m_eops++;
      end
      if (rec) begin
        if (vcnt < 16) begin
          sop_mask[vcnt] = bus.out_sop;
          eop_mask[vcnt] = bus.out_eop;
        end
        if (bus.out_sop) sop_lens.push_back(int'(bus.out_len));
        vcnt++;
      end
    end else begin
      chk("idle_frame", 64'({bus.out_sop, bus.out_eop, bus.out_len}), 0);
    end
`ifdef PKT_RD_SCHED_STATS_EN
    chk("pkt_in_cnt", 64'(pkt_in_cnt), 64'(m_pushes));
    chk("pkt_out_cnt", 64'(pkt_out_cnt), 64'(m_eops));
`endif
    if (rec && rd) rd_cyc_q.push_back(cyc);
    if (acc) m_write(bus.wr_sop, bus.wr_eop);
    last_acc = acc;
    prev_rd = rd;
    @(posedge clk);
    #1;
    cyc++;
    ram_cnt = ram_cnt + int'(acc) - int'(rd);
    bus.ram_full  = (ram_cnt >= ram_cap);
    bus.ram_empty = (ram_cnt == 0);
    if (rand_rdy) bus.out_ready = ($urandom_range(0, 9) < 7);
  endtask

  task automatic send_word(bit sop, bit eop);
    int n = 0;
    bus.wr_valid = 1;
    bus.wr_sop = sop;
    bus.wr_eop = eop;
    do begin
      tick();
      n++;
    end while (!last_acc && n < 400);
    if (!last_acc) chk("wr_accept_timeout", 0, 1);
    bus.wr_valid = 0;
    bus.wr_sop = 0;
    bus.wr_eop = 0;
  endtask

  task automatic send_pkt(int len);
    for (int i = 0; i < len; i++) send_word(i == 0, i == len - 1);
  endtask

  task automatic drain(int bound);
    int n = 0;
    rand_rdy = 0;
    bus.out_ready = 1;
    while ((exp_q.size() != 0 || prev_rd) && n < bound) begin
      tick();
      n++;
    end
    chk("drain_done", 64'(exp_q.size()), 0);
    tick();
    chk("desc_drained", 64'(bus.desc_count), 0);
    chk("ram_drained", 64'(ram_cnt), 0);
  endtask

  task automatic rec_start();
    rd_cyc_q.delete();
    sop_lens.delete();
    sop_mask = '0;
    eop_mask = '0;
    vcnt = 0;
    rec = 1;
  endtask

  task automatic chk_reset_outputs(string tag);
    chk({tag, "_valid"}, 64'(bus.out_valid), 0);
    chk({tag, "_sop"}, 64'(bus.out_sop), 0);
    chk({tag, "_eop"}, 64'(bus.out_eop), 0);
    chk({tag, "_len"}, 64'(bus.out_len), 0);
    chk({tag, "_rd_en"}, 64'(bus.ram_rd_en), 0);
    chk({tag, "_desc_count"}, 64'(bus.desc_count), 0);
    chk({tag, "_err_framing"}, 64'(bus.err_framing), 0);
    chk({tag, "_err_oversize"}, 64'(bus.err_oversize), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    bus.wr_valid = 0; bus.wr_sop = 0; bus.wr_eop = 0;
    bus.ram_full = 0; bus.ram_empty = 1; bus.out_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("in_reset");
    rst_n = 1;
    tick();
    chk_reset_outputs("after_reset");

    // Lengths 1,3,5 queued behind a stalled reader, then released: 9 issues, no bubble.
    bus.out_ready = 0;
    send_pkt(1); send_pkt(3); send_pkt(5);
    tick(); tick();
    rec_start();
    bus.out_ready = 1;
    repeat (14) tick();
    rec = 0;
    chk("t1_rd_count", 64'(rd_cyc_q.size()), 9);
    if (rd_cyc_q.size() == 9) chk("t1_no_bubble", 64'(rd_cyc_q[8] - rd_cyc_q[0]), 8);
    chk("t1_valid_count", 64'(vcnt), 9);
    chk("t1_sop_mask", 64'(sop_mask[8:0]), 64'(9'b000010011));
    chk("t1_eop_mask", 64'(eop_mask[8:0]), 64'(9'b100001001));
    chk("t1_len_count", 64'(sop_lens.size()), 3);
    if (sop_lens.size() == 3) begin
      chk("t1_len0", 64'(sop_lens[0]), 1);
      chk("t1_len1", 64'(sop_lens[1]), 3);
      chk("t1_len2", 64'(sop_lens[2]), 5);
    end
    drain(100);

    // 4-word packet with credit toggling 1010...
    bus.out_ready = 0;
    send_pkt(4);
    rec_start();
    for (int i = 0; i < 12; i++) begin
      bus.out_ready = (i % 2 == 0);
      tick();
    end
    rec = 0;
    chk("t2_rd_count", 64'(rd_cyc_q.size()), 4);
    for (int i = 0; i + 1 < rd_cyc_q.size(); i++)
      chk("t2_rd_spacing", 64'(rd_cyc_q[i + 1] - rd_cyc_q[i]), 2);
    chk("t2_eop_mask", 64'(eop_mask[3:0]), 64'(4'b1000));
    chk("t2_sop_mask", 64'(sop_mask[3:0]), 64'(4'b0001));
    drain(100);

    // 17 single-word packets with the reader stalled: one popped, 16 queued, back-pressure.
    bus.out_ready = 0;
    for (int i = 0; i < 17; i++) send_word(1, 1);
    bus.wr_valid = 1; bus.wr_sop = 1; bus.wr_eop = 1;
    tick();
    chk("t3_desc_full_count", 64'(bus.desc_count), 16);
    chk("t3_wr_ready_low", 64'(obs_wr_ready), 0);
    chk("t3_held_word", 64'(last_acc), 0);
    bus.out_ready = 1;
    begin
      int n = 0;
      do begin
        tick();
        n++;
      end while (!last_acc && n < 5);
      chk("t3_released", 64'(last_acc), 1);
    end
    bus.wr_valid = 0; bus.wr_sop = 0; bus.wr_eop = 0;
    drain(200);

    // Randomized well-framed traffic with random credit and a small RAM.
    ram_cap = 8;
    rand_rdy = 1;
    for (int p = 0; p < 40; p++) begin
      len = $urandom_range(1, 6);
      send_pkt(len);
      repeat ($urandom_range(0, 2)) tick();
    end
    drain(2000);
    ram_cap = 8192;

    // Oversize: MAXL+5 words in one packet -> descriptors MAXL and 5, no framing error.
    rec_start();
    bus.out_ready = 1;
    send_pkt(MAXL + 5);
    drain(MAXL + 200);
    rec = 0;
    chk("t5_err_oversize", 64'(bus.err_oversize), 1);
    chk("t5_err_framing", 64'(bus.err_framing), 0);
    chk("t5_len_count", 64'(sop_lens.size()), 2);
    if (sop_lens.size() == 2) begin
      chk("t5_len0", 64'(sop_lens[0]), 64'(MAXL));
      chk("t5_len1", 64'(sop_lens[1]), 5);
    end

    // Missing SOP then double SOP.
    rec_start();
    send_word(0, 0); send_word(0, 1);
    send_word(1, 0); send_word(1, 0); send_word(0, 1);
    tick();
    chk("t4_err_framing_set", 64'(bus.err_framing), 1);
    drain(100);
    rec = 0;
    chk("t4_err_framing_sticky", 64'(bus.err_framing), 1);
    chk("t4_len_count", 64'(sop_lens.size()), 2);
    if (sop_lens.size() == 2) begin
      chk("t4_len0", 64'(sop_lens[0]), 2);
      chk("t4_len1", 64'(sop_lens[1]), 3);
    end

    // Reset in the middle of an 8-word burst, then a fresh 2-word packet.
    bus.out_ready = 1;
    send_pkt(8);
    repeat (4) tick();
    chk("t6_mid_burst", 64'(prev_rd), 1);
    rst_n = 0;
    @(negedge clk);
    chk_reset_outputs("t6_reset");
    @(posedge clk);
    #1;
    rst_n = 1;
    exp_q.delete();
    ram_cnt = 0; prev_rd = 0; last_acc = 0;
    m_in_pkt = 0; m_ovf = 0; m_frm = 0; m_ovs = 0; m_len = 0;
    m_pushes = 0; m_eops = 0;
    bus.ram_full = 0; bus.ram_empty = 1;
    rec_start();
    send_pkt(2);
    drain(100);
    rec = 0;
    chk("t6_len_count", 64'(sop_lens.size()), 1);
    if (sop_lens.size() == 1) chk("t6_len0", 64'(sop_lens[0]), 2);
    chk("t6_err_framing", 64'(bus.err_framing), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
